// File: rtl/priority_arbiter_4.sv
// priority_arbiter_4: fixed-priority 4-way arbiter with hold limit, one-cycle turnaround
// and a one-shot skip of a requester whose grant was forcibly released.
module priority_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [7:0] MAX     = 8'(MAX_HOLD);

    logic [1:0] state;
    logic [3:0] mask;
    logic [7:0] cnt;
    logic [3:0] elig;
    logic [1:0] win;

    always_comb begin
        elig = req & ~mask;
        win  = elig[3] ? 2'd3 : elig[2] ? 2'd2 : elig[1] ? 2'd1 : 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 4'b0;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            mask      <= 4'b0;
            cnt       <= 8'd0;
        end else begin
            case (state)
                GRANT: begin
                    if (done || !req[gnt_id] || cnt == MAX) begin
                        state     <= RELEASE;
                        gnt       <= 4'b0;
                        gnt_id    <= 2'd0;
                        gnt_valid <= 1'b0;
                        cnt       <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                    // done and a dropped request both take precedence over the hold limit
                    if (!done && req[gnt_id] && cnt == MAX) begin
                        timeout <= 1'b1;
                        mask    <= gnt;
                    end
                end
                default: begin
                    timeout <= 1'b0;
                    mask    <= 4'b0;
                    if (|elig) begin
                        state     <= GRANT;
                        gnt       <= 4'b1 << win;
                        gnt_id    <= win;
                        gnt_valid <= 1'b1;
                        cnt       <= 8'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_priority_arbiter_4.sv
// tb_priority_arbiter_4: directed scenarios plus random traffic checked against a
// behavioural model of holder/hold-length/skip semantics.
module tb_priority_arbiter_4;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_chk = 0;
    int n_fail = 0;

    // model state
    int m_holder = -1;
    int m_len = 0;
    int m_skip = -1;
    bit m_to = 0;
    bit m_prev_to = 0;

    priority_arbiter_4 #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int skip);
        for (int i = 3; i >= 0; i--)
            if (r[i] && i != skip) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_holder = -1; m_len = 0; m_skip = -1; m_to = 0; m_prev_to = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic d);
        int w;
        m_prev_to = m_to;
        if (m_holder >= 0) begin
            if (d || !r[m_holder]) begin
                m_holder = -1; m_to = 0;
            end else if (m_len == MH) begin
                m_skip = m_holder; m_holder = -1; m_to = 1;
            end else begin
                m_len++;
            end
        end else begin
            w = pick(r, m_skip);
            m_skip = -1; m_to = 0;
            if (w >= 0) begin
                m_holder = w; m_len = 1;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [3:0] eg;
        logic [1:0] ei;
        eg = (m_holder >= 0) ? 4'(1 << m_holder) : 4'b0;
        ei = (m_holder >= 0) ? 2'(m_holder) : 2'd0;
        n_chk++;
        assert (gnt === eg) else begin n_fail++; $error("FAIL %s gnt: observed %b expected %b", tag, gnt, eg); end
        n_chk++;
        assert (gnt_id === ei) else begin n_fail++; $error("FAIL %s gnt_id: observed %0d expected %0d", tag, gnt_id, ei); end
        n_chk++;
        assert (gnt_valid === (m_holder >= 0)) else begin n_fail++; $error("FAIL %s gnt_valid: observed %b expected %b", tag, gnt_valid, m_holder >= 0); end
        n_chk++;
        assert (timeout === m_to) else begin n_fail++; $error("FAIL %s timeout: observed %b expected %b", tag, timeout, m_to); end
        n_chk++;
        assert (!(timeout && m_prev_to)) else begin n_fail++; $error("FAIL %s timeout_run: observed %b expected 0", tag, timeout); end
    endtask

    task automatic step(input logic [3:0] r, input logic d, input string tag);
        req = r; done = d;
        @(posedge clk);
        model_edge(r, d);
        #1 check(tag);
    endtask

    initial begin
        rst = 1'b1; req = 4'b0; done = 1'b0;
        #12;
        model_reset();
        check("reset");
        @(negedge clk) rst = 1'b0;
        #1;

        // single request, done release
        step(4'b0000, 0, "idle");
        step(4'b0010, 0, "single_g1");
        n_chk++;
        assert (gnt_id === 2'd1) else begin n_fail++; $error("FAIL single_id: observed %0d expected 1", gnt_id); end
        step(4'b0010, 1, "single_rel");
        step(4'b0000, 0, "single_idle");

        // priority without preemption
        step(4'b0101, 0, "prio_g2");
        step(4'b1101, 0, "prio_hold");
        step(4'b1101, 0, "prio_hold2");
        step(4'b1101, 1, "prio_rel");
        step(4'b1101, 0, "prio_g3");
        n_chk++;
        assert (gnt_id === 2'd3) else begin n_fail++; $error("FAIL prio_next: observed %0d expected 3", gnt_id); end
        step(4'b0000, 0, "prio_drop");
        step(4'b0000, 0, "prio_idle");

        // timeout and skip
        for (int i = 0; i < MH; i++) step(4'b1001, 0, "to_hold");
        step(4'b1001, 0, "to_rel");
        n_chk++;
        assert (timeout === 1'b1) else begin n_fail++; $error("FAIL to_pulse: observed %b expected 1", timeout); end
        step(4'b1001, 0, "to_skip");
        n_chk++;
        assert (gnt_id === 2'd0 && gnt_valid === 1'b1) else begin n_fail++; $error("FAIL to_skip_id: observed %0d expected 0", gnt_id); end
        step(4'b1001, 1, "to_done");
        step(4'b1001, 0, "to_back3");

        // done versus timeout tie on the last hold cycle
        for (int i = 1; i < MH; i++) step(4'b1001, 0, "tie_hold");
        step(4'b1001, 1, "tie_rel");
        step(4'b1001, 0, "tie_regrant");
        n_chk++;
        assert (gnt_id === 2'd3 && timeout === 1'b0) else begin n_fail++; $error("FAIL tie_nomask: observed %0d expected 3", gnt_id); end
        step(4'b0000, 0, "tie_drop");
        step(4'b0000, 0, "tie_idle");

        // lone masked requester
        for (int i = 0; i < MH + 4; i++) step(4'b0010, 0, "lone");
        step(4'b0000, 0, "lone_drop");
        step(4'b0000, 0, "lone_idle");

        // asynchronous reset mid-grant
        step(4'b1000, 0, "ar_g");
        step(4'b1000, 0, "ar_g2");
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_chk++;
        assert (gnt === 4'b0 && gnt_id === 2'd0 && gnt_valid === 1'b0 && timeout === 1'b0)
            else begin n_fail++; $error("FAIL async_rst: observed %b/%0d/%b/%b expected 0", gnt, gnt_id, gnt_valid, timeout); end
        @(negedge clk) rst = 1'b0;
        #1;
        step(4'b0100, 0, "ar_after");
        n_chk++;
        assert (gnt_id === 2'd2) else begin n_fail++; $error("FAIL ar_after_id: observed %0d expected 2", gnt_id); end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (gnt_valid ? (req | 4'(1 << gnt_id)) : 4'($urandom));
            step(r, ($urandom_range(0, 5) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/priority_arbiter_4.md
PRIORITY_ARBITER_4 -- requirements
Module: priority_arbiter_4

Interface
REQ-001 SHALL provide parameter: MAX_HOLD, default 8, the maximum number of cycles one grant is held before forced release (legal range 2..255).
REQ-002 SHALL provide the following ports (one clock; reset is asynchronous and active-high):
clk  input  1  sole clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  4  request lines; req[3] is highest priority, req[0] is lowest.
done  input  1  current holder releases the resource; sampled only in GRANT.
gnt  output  4  one-hot grant, or all-zero.
gnt_id  output  2  encoded index of the granted requester; 0 when gnt_valid=0.
gnt_valid  output  1  high while any grant is active.
timeout  output  1  one-cycle pulse marking a forced release.
REQ-003 SHALL drive all outputs from registers, with no combinational path from any input to any output.

Function
REQ-004 SHALL implement a three-state FSM: IDLE, GRANT, RELEASE.
REQ-005 Winner selection: the highest set index of (req & ~mask), where mask is a 4-bit one-hot exclusion register that is zero unless set by REQ-011.
REQ-006 In IDLE, if (req & ~mask) != 0 at a rising edge, SHALL enter GRANT with the winner's outputs valid from the next cycle; a 1-cycle request-to-grant latency.
REQ-007 In IDLE with no eligible request, SHALL stay in IDLE with gnt=0, gnt_id=0, gnt_valid=0.
REQ-008 On entry to GRANT, SHALL load the hold counter (8 bits) to 1 and increment it once per cycle spent in GRANT.
REQ-009 While in GRANT, gnt, gnt_id and gnt_valid SHALL stay constant; higher-priority requests arriving mid-grant SHALL NOT preempt the holder.
REQ-010 In GRANT, if done=1 or req[gnt_id]=0, SHALL go to RELEASE with timeout=0.
REQ-011 In GRANT, if neither REQ-010 condition holds and the counter equals MAX_HOLD, SHALL go to RELEASE, pulse timeout=1 during the RELEASE cycle, and set mask to the one-hot of the released gnt_id.
REQ-012 When done=1 in the same cycle the counter reaches MAX_HOLD, done SHALL win: no timeout, no mask.
REQ-013 In RELEASE, gnt=0, gnt_id=0, gnt_valid=0 for exactly one cycle (a bus turnaround).
REQ-014 At the end of RELEASE, if (req & ~mask) != 0, SHALL go directly to GRANT with the REQ-005 winner; otherwise SHALL go to IDLE.
REQ-015 mask SHALL be cleared at the end of the first arbitration evaluated after it was set, whether in RELEASE or IDLE, so that a timed-out requester is skipped exactly once.
REQ-016 If the only requester is masked at the end of RELEASE, SHALL go to IDLE with mask cleared, and that requester SHALL be granted one cycle later.
REQ-017 gnt SHALL always be zero or one-hot and SHALL equal 1<<gnt_id whenever gnt_valid=1.
REQ-018 timeout SHALL never be high for more than one consecutive cycle.

Reset
REQ-019 While rst=1, asynchronously and without waiting for clk: state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, mask=0, counter=0.
REQ-020 Reset asserted mid-GRANT or mid-RELEASE SHALL abort the grant immediately.
REQ-021 After rst deasserts, the first arbitration SHALL occur on the first rising edge, per REQ-006.

Verification
REQ-022 Single request: req=4'b0010 in IDLE -> next cycle gnt=0010, gnt_id=1, gnt_valid=1; done pulse -> one RELEASE cycle with gnt=0, then IDLE.
REQ-023 Priority with no preemption: req=4'b0101 -> gnt_id=2; req[3] raised mid-grant -> gnt_id stays 2 until done; after RELEASE -> gnt_id=3.
REQ-024 Timeout and skip: MAX_HOLD=4, req=4'b1001 held, no done -> gnt_id=3 for 4 cycles, RELEASE with timeout=1, then gnt_id=0; after done -> gnt_id=3 again.
REQ-025 Done versus timeout tie: MAX_HOLD=4, done asserted on the 4th grant cycle -> timeout=0, mask=0.
REQ-026 Lone masked requester: MAX_HOLD=2, only req[1] held -> timeout, then RELEASE, IDLE, GRANT gnt_id=1 (two-cycle gap).
REQ-027 Asynchronous reset mid-GRANT: rst pulsed between clock edges -> all outputs 0 immediately; after release, req=4'b0100 -> gnt_id=2 after one cycle.
